// File: rtl/rob_pr_free_q_if.sv
// Commit-to-free-list port bundle for rob_pr_free_q: bundle enqueue plus per-bank drain handshake.
// The queue uses the slave modport; the commit stage and free-list banks sit on the master side.
interface rob_pr_free_q_if #(
  parameter int LANES        = 4,
  parameter int LOG_PR_COUNT = 7,
  parameter int BANK_COUNT   = 4
);
  logic                               enq_valid;
  logic [LANES-1:0]                   enq_valid_by_lane;
  logic [LANES*LOG_PR_COUNT-1:0]      enq_PR_by_lane;
  logic                               enq_ready;
  logic [BANK_COUNT-1:0]              deq_valid_by_bank;
  logic [BANK_COUNT*LOG_PR_COUNT-1:0] deq_PR_by_bank;
  logic [BANK_COUNT-1:0]              deq_ready_by_bank;
  logic                               empty;

  modport slave (
    input  enq_valid, enq_valid_by_lane, enq_PR_by_lane, deq_ready_by_bank,
    output enq_ready, deq_valid_by_bank, deq_PR_by_bank, empty
  );

  modport master (
    output enq_valid, enq_valid_by_lane, enq_PR_by_lane, deq_ready_by_bank,
    input  enq_ready, deq_valid_by_bank, deq_PR_by_bank, empty
  );
endinterface

// File: rtl/rob_pr_free_q.sv
// Freed-PR bundle queue between ROB commit and the banked free list; drains one PR per bank per cycle.
// Optional counters enabled by defining ROB_PR_FREE_Q_PERF_EN.
module rob_pr_free_q #(
  parameter int ENTRIES    = 2,
  parameter int LANES      = 4,
  parameter int PR_COUNT   = 128,
  parameter int BANK_COUNT = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  rob_pr_free_q_if.slave   q
`ifdef ROB_PR_FREE_Q_PERF_EN
  ,
  output logic [31:0]      perf_enq_stall_count,
  output logic [31:0]      perf_bank_conflict_count
`endif
);
  localparam int LOG_PR_COUNT   = $clog2(PR_COUNT);
  localparam int LOG_BANK_COUNT = $clog2(BANK_COUNT);
  localparam int PTR_W          = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W          = $clog2(ENTRIES + 1);

  logic [LOG_PR_COUNT-1:0] pr_q  [ENTRIES][LANES];
  logic [LANES-1:0]        rem_q [ENTRIES];
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [CNT_W-1:0]        count_q;

  logic                    not_empty;
  logic                    enq_fire, enq_take, pop;
  logic [LANES-1:0]        head_rem;
  logic [LANES-1:0]        sel_oh [BANK_COUNT];
  logic [LOG_PR_COUNT-1:0] sel_pr [BANK_COUNT];
  logic [LANES-1:0]        sel_any, fired;
  logic [BANK_COUNT-1:0]   deq_valid;
  logic [BANK_COUNT*LOG_PR_COUNT-1:0] deq_pr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_empty   = (count_q != '0);
  assign q.empty     = !not_empty;
  assign q.enq_ready = (count_q != CNT_W'(ENTRIES));
  assign enq_fire    = q.enq_valid && q.enq_ready;
  assign enq_take    = enq_fire && (q.enq_valid_by_lane != '0);
  assign head_rem    = not_empty ? rem_q[head_q] : '0;

  // Per bank, the lowest remaining lane wins; the descending scan lets lower lanes overwrite.
  always_comb begin
    sel_any = '0;
    fired   = '0;
    deq_valid = '0;
    deq_pr    = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      sel_oh[b] = '0;
      sel_pr[b] = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
        if (head_rem[i] &&
            (pr_q[head_q][i][LOG_BANK_COUNT-1:0] == LOG_BANK_COUNT'(b))) begin
          sel_oh[b]    = '0;
          sel_oh[b][i] = 1'b1;
          sel_pr[b]    = pr_q[head_q][i];
        end
      end
      deq_valid[b] = (sel_oh[b] != '0);
      deq_pr[b*LOG_PR_COUNT +: LOG_PR_COUNT] = sel_pr[b];
      sel_any = sel_any | sel_oh[b];
      if (deq_valid[b] && q.deq_ready_by_bank[b]) fired = fired | sel_oh[b];
    end
  end

  assign q.deq_valid_by_bank = deq_valid;
  assign q.deq_PR_by_bank    = deq_pr;
  assign pop = not_empty && ((head_rem & ~fired) == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        rem_q[e] <= '0;
        for (int i = 0; i < LANES; i++) pr_q[e][i] <= '0;
      end
    end else begin
      if (not_empty) rem_q[head_q] <= rem_q[head_q] & ~fired;
      // Tail can only equal a live head when full, so this write never collides with the drain.
      if (enq_take) begin
        rem_q[tail_q] <= q.enq_valid_by_lane;
        for (int i = 0; i < LANES; i++)
          pr_q[tail_q][i] <= q.enq_PR_by_lane[i*LOG_PR_COUNT +: LOG_PR_COUNT];
        tail_q <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      case ({enq_take, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ROB_PR_FREE_Q_PERF_EN
  logic bank_conflict;
  assign bank_conflict = (head_rem & ~sel_any) != '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_enq_stall_count     <= '0;
      perf_bank_conflict_count <= '0;
    end else begin
      if (q.enq_valid && !q.enq_ready && (perf_enq_stall_count != '1))
        perf_enq_stall_count <= perf_enq_stall_count + 1'b1;
      if (bank_conflict && (perf_bank_conflict_count != '1))
        perf_bank_conflict_count <= perf_bank_conflict_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_pr_free_q.sv
// Directed bench for rob_pr_free_q (ENTRIES=2, LANES=4, PR_COUNT=128, BANK_COUNT=4).
module tb_rob_pr_free_q;
  localparam int LPR = 7;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  rob_pr_free_q_if #(.LANES(4), .LOG_PR_COUNT(LPR), .BANK_COUNT(4)) dif ();

`ifdef ROB_PR_FREE_Q_PERF_EN
  logic [31:0] perf_stall, perf_conf;
`endif

  rob_pr_free_q #(.ENTRIES(2), .LANES(4), .PR_COUNT(128), .BANK_COUNT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .q    (dif.slave)
`ifdef ROB_PR_FREE_Q_PERF_EN
    ,
    .perf_enq_stall_count     (perf_stall),
    .perf_bank_conflict_count (perf_conf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LPR-1:0] pr_at(input int b);
    return dif.deq_PR_by_bank[b*LPR +: LPR];
  endfunction

  task automatic set_enq(input logic v, input logic [3:0] lanes,
                         input int p0, input int p1, input int p2, input int p3);
    dif.enq_valid         = v;
    dif.enq_valid_by_lane = lanes;
    dif.enq_PR_by_lane    = {LPR'(p3), LPR'(p2), LPR'(p1), LPR'(p0)};
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    dif.deq_ready_by_bank = 4'b1111;
    #2;
    check("rst_enq_ready", 64'(dif.enq_ready), 64'd1);
    check("rst_empty", 64'(dif.empty), 64'd1);
    check("rst_deq_valid", 64'(dif.deq_valid_by_bank), 64'd0);
    check("rst_deq_pr", 64'(dif.deq_PR_by_bank), 64'd0);
    #10 nRST = 1'b1;
    tick;

    // distinct banks drain in one cycle
    set_enq(1'b1, 4'b1111, 4, 9, 14, 19);
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t1_valid", 64'(dif.deq_valid_by_bank), 64'hf);
    check("t1_pr0", 64'(pr_at(0)), 64'd4);
    check("t1_pr1", 64'(pr_at(1)), 64'd9);
    check("t1_pr2", 64'(pr_at(2)), 64'd14);
    check("t1_pr3", 64'(pr_at(3)), 64'd19);
    check("t1_not_empty", 64'(dif.empty), 64'd0);
    tick;
    check("t1_empty", 64'(dif.empty), 64'd1);
    check("t1_valid_after", 64'(dif.deq_valid_by_bank), 64'd0);

    // same-bank lanes serialize in lane order
    set_enq(1'b1, 4'b0111, 8, 12, 16, 0);
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t2_v0", 64'(dif.deq_valid_by_bank), 64'h1);
    check("t2_pr_a", 64'(pr_at(0)), 64'd8);
    tick;
    check("t2_pr_b", 64'(pr_at(0)), 64'd12);
    check("t2_not_empty_b", 64'(dif.empty), 64'd0);
    tick;
    check("t2_pr_c", 64'(pr_at(0)), 64'd16);
    check("t2_v2", 64'(dif.deq_valid_by_bank), 64'h1);
    tick;
    check("t2_empty", 64'(dif.empty), 64'd1);
`ifdef ROB_PR_FREE_Q_PERF_EN
    check("t2_stall_cnt", 64'(perf_stall), 64'd0);
    check("t2_conf_cnt", 64'(perf_conf), 64'd2);
`endif

    // fill, then held-off enqueue is ignored
    dif.deq_ready_by_bank = 4'b0000;
    set_enq(1'b1, 4'b0001, 5, 0, 0, 0);
    tick;
    check("t3_ready_one", 64'(dif.enq_ready), 64'd1);
    set_enq(1'b1, 4'b0001, 6, 0, 0, 0);
    tick;
    check("t3_full", 64'(dif.enq_ready), 64'd0);
    check("t3_full_not_empty", 64'(dif.empty), 64'd0);
    set_enq(1'b1, 4'b0001, 77, 0, 0, 0);
    tick;
    tick;
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t3_still_full", 64'(dif.enq_ready), 64'd0);
`ifdef ROB_PR_FREE_Q_PERF_EN
    check("t3_stall_cnt", 64'(perf_stall), 64'd3);
`endif
    check("t3_head_v", 64'(dif.deq_valid_by_bank), 64'h2);
    check("t3_head_pr", 64'(pr_at(1)), 64'd5);
    dif.deq_ready_by_bank = 4'b1111;
    tick;
    check("t3_second_v", 64'(dif.deq_valid_by_bank), 64'h4);
    check("t3_second_pr", 64'(pr_at(2)), 64'd6);
    tick;
    check("t3_drained", 64'(dif.empty), 64'd1);

    // partial ready: banks hold until their own ready
    dif.deq_ready_by_bank = 4'b0100;
    set_enq(1'b1, 4'b0111, 1, 2, 3, 0);
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t4_v_all", 64'(dif.deq_valid_by_bank), 64'he);
    check("t4_pr2", 64'(pr_at(2)), 64'd2);
    tick;
    check("t4_v_hold", 64'(dif.deq_valid_by_bank), 64'ha);
    check("t4_pr1", 64'(pr_at(1)), 64'd1);
    check("t4_pr3", 64'(pr_at(3)), 64'd3);
    dif.deq_ready_by_bank = 4'b0010;
    tick;
    check("t4_v_last", 64'(dif.deq_valid_by_bank), 64'h8);
    check("t4_no_pop", 64'(dif.empty), 64'd0);
    dif.deq_ready_by_bank = 4'b1000;
    tick;
    check("t4_empty", 64'(dif.empty), 64'd1);

    // enq+pop at count 1, zero-mask bundle, pointer wrap over 5 bundles
    dif.deq_ready_by_bank = 4'b1111;
    set_enq(1'b1, 4'b0001, 20, 0, 0, 0);
    tick;
    check("t5_b1", 64'(pr_at(0)), 64'd20);
    set_enq(1'b1, 4'b0001, 21, 0, 0, 0);
    tick;
    check("t5_b2_v", 64'(dif.deq_valid_by_bank), 64'h2);
    check("t5_b2_pr", 64'(pr_at(1)), 64'd21);
    check("t5_b2_ready", 64'(dif.enq_ready), 64'd1);
    set_enq(1'b1, 4'b0000, 99, 99, 99, 99);
    tick;
    check("t5_zero_mask_empty", 64'(dif.empty), 64'd1);
    set_enq(1'b1, 4'b0001, 22, 0, 0, 0);
    tick;
    check("t5_b3_v", 64'(dif.deq_valid_by_bank), 64'h4);
    check("t5_b3_pr", 64'(pr_at(2)), 64'd22);
    set_enq(1'b1, 4'b0001, 23, 0, 0, 0);
    tick;
    check("t5_b4_v", 64'(dif.deq_valid_by_bank), 64'h8);
    check("t5_b4_pr", 64'(pr_at(3)), 64'd23);
    set_enq(1'b1, 4'b0001, 24, 0, 0, 0);
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t5_b5_v", 64'(dif.deq_valid_by_bank), 64'h1);
    check("t5_b5_pr", 64'(pr_at(0)), 64'd24);
    tick;
    check("t5_empty", 64'(dif.empty), 64'd1);

    // async reset mid-drain
    dif.deq_ready_by_bank = 4'b0000;
    set_enq(1'b1, 4'b1111, 4, 9, 14, 19);
    tick;
    set_enq(1'b1, 4'b0111, 8, 12, 16, 0);
    tick;
    set_enq(1'b0, 4'b0000, 0, 0, 0, 0);
    check("t6_full", 64'(dif.enq_ready), 64'd0);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_valid", 64'(dif.deq_valid_by_bank), 64'd0);
    check("t6_rst_empty", 64'(dif.empty), 64'd1);
    check("t6_rst_ready", 64'(dif.enq_ready), 64'd1);
    check("t6_rst_pr", 64'(dif.deq_PR_by_bank), 64'd0);
`ifdef ROB_PR_FREE_Q_PERF_EN
    check("t6_rst_stall", 64'(perf_stall), 64'd0);
`endif
    #10 nRST = 1'b1;
    dif.deq_ready_by_bank = 4'b1111;
    tick;
    check("t6_after_empty", 64'(dif.empty), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_pr_free_q.md
Name: rob_pr_free_q

Overview:
- Commit-side producer of freed physical registers (PRs), feeding the banked free list.
- Each cycle the ROB commit stage enqueues one bundle of up to LANES freed PRs.
- The queue holds up to ENTRIES bundles and drains the head bundle to the free list one PR per bank per cycle, with a per-bank valid/ready handshake.
- Lanes whose PRs map to the same bank are serialized across cycles.

Parameters:
ENTRIES, 2, bundle slots (ROB_PR_FREE_Q_ENTRIES); any value >= 1
LANES, 4, commit lanes per bundle
PR_COUNT, 128, physical registers; LOG_PR_COUNT = $clog2(PR_COUNT)
BANK_COUNT, 4, free-list/PRF banks; LOG_BANK_COUNT = $clog2(BANK_COUNT); bank of a PR = PR[LOG_BANK_COUNT-1:0]

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
enq_valid  in  1  commit bundle present
enq_valid_by_lane  in  LANES  lane i frees a PR
enq_PR_by_lane  in  LANES*LOG_PR_COUNT  freed PR per lane
enq_ready  out  1  slot available (registered-state only)
deq_valid_by_bank  out  BANK_COUNT  PR offered to bank b
deq_PR_by_bank  out  BANK_COUNT*LOG_PR_COUNT  PR offered to bank b
deq_ready_by_bank  in  BANK_COUNT  free-list bank b accepts
empty  out  1  no bundles held

Behaviour:
- State:
  - Per slot: PR array and a remaining mask (LANES bits).
  - Head pointer, tail pointer, and an occupancy count in 0..ENTRIES.
  - Pointers wrap from ENTRIES-1 to 0; ENTRIES is not required to be a power of 2.
- Reset (async, nRST low): count=0, head=tail=0, all remaining masks=0. Outputs during and right after reset: enq_ready=1, empty=1, deq_valid_by_bank=0, deq_PR_by_bank=0.
- enq_ready = (count != ENTRIES).
  - It does not depend on same-cycle dequeue, so there is no comb path from deq_ready to enq_ready.
- Enqueue fires when enq_valid && enq_ready.
  - Write PRs and remaining = enq_valid_by_lane into slot[tail], then advance tail.
  - A bundle with enq_valid_by_lane == 0 is accepted and discarded; tail and count do not change.
  - enq_valid while full is held off by the producer; the block ignores it.
- Head drain, combinational from registered state:
  - For each bank b, select the lowest-index lane i of slot[head] with remaining[i]=1 and PR_i bank == b.
  - deq_valid_by_bank[b] = (count != 0) && a lane was selected.
  - deq_PR_by_bank[b] = the selected PR, else 0.
- Bank b fires when deq_valid_by_bank[b] && deq_ready_by_bank[b]; the selected lane's remaining bit clears on the next edge.
- At most BANK_COUNT lanes drain per cycle, one per bank.
- Pop: when remaining of the head AND NOT (fired lanes this cycle) == 0, advance head and free the slot.
  - The new head is presented on the following cycle; there is no same-cycle look-through to the next slot.
- Simultaneous enqueue and pop: count unchanged. Enqueue only: count+1. Pop only: count-1.
- empty = (count == 0).
- Bubble-free drain: a bundle with all lanes in distinct banks drains in 1 cycle with all banks ready, giving 1 bundle/cycle sustained throughput.
- Ordering:
  - Bundles drain in FIFO order.
  - Within a bank, lanes drain in ascending lane order.
  - Different banks drain independently within the head bundle.
- Reset mid-drain discards all held bundles. The freed PRs are recovered by free-list reinitialization, not by this block.

Optional Feature:
- Macro: ROB_PR_FREE_Q_PERF_EN.
- When defined, two extra outputs are added:
  - perf_enq_stall_count (32 bits): counts cycles with enq_valid && !enq_ready.
  - perf_bank_conflict_count (32 bits): counts cycles where the head slot has remaining lanes that are not selected in any bank because of same-bank serialization.
  - Both counters reset to 0 and saturate at 2^32-1.
- When not defined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then enq lanes 1111 with PRs 4,9,14,19 (banks 0,1,2,3), all deq_ready=1 → next cycle all four deq_valid with PRs 4,9,14,19; following cycle empty=1.
- Same-bank bundle: PRs 8,12,16 on lanes 0,1,2 (all bank 0), ready=1 → bank 0 emits 8, then 12, then 16 on consecutive cycles; pop after the third; the stall counter does not increment.
- Fill: enqueue 2 bundles with all deq_ready=0 → enq_ready=0, count=2. Enq_valid then asserted with PR 77 for 3 cycles → ignored; with PERF_EN, perf_enq_stall_count=3.
- Partial ready: bundle PRs 1,2,3 with only bank 2 ready → PR 2 drains; banks 1/3 hold 1 and 3 until ready; no pop until both drain.
- Simultaneous enq+pop at count=1, and enq of a lane-mask-0 bundle → count stays 1 and tail is unchanged respectively; pointer wrap verified over 5 bundles at ENTRIES=2.
- Async nRST asserted mid-drain with 2 bundles held → deq_valid_by_bank=0 and empty=1 immediately, without waiting for a CLK edge.
